// File: rtl/pixel_proc.sv
// Three-stage per-pixel colour classifier: RGB in, 3-bit hue class out.
// Hue bands are tested by cross-multiplication against delta, so there is no divider.
module pixel_proc #(
  parameter int unsigned V_MIN = 64,
  parameter int unsigned S_MIN = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  output logic [2:0]  pixel_classification
);

  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_G = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;

  logic [23:0]       pix_q;
  logic [7:0]        max_q;
  logic [7:0]        delta_q;
  logic [1:0]        sel_q;
  logic signed [8:0] diff_q;

  logic [7:0]        r, g, b;
  logic [7:0]        max_c, min_c;
  logic [1:0]        sel_c;
  logic signed [8:0] diff_c;

  // Stage 2 combinational: extremes, max-channel select (R > G > B on ties)
  always_comb begin
    r = pix_q[23:16];
    g = pix_q[15:8];
    b = pix_q[7:0];
    if (r >= g && r >= b) begin
      sel_c  = SEL_R;
      max_c  = r;
      diff_c = $signed({1'b0, g}) - $signed({1'b0, b});
    end else if (g >= b) begin
      sel_c  = SEL_G;
      max_c  = g;
      diff_c = $signed({1'b0, b}) - $signed({1'b0, r});
    end else begin
      sel_c  = SEL_B;
      max_c  = b;
      diff_c = $signed({1'b0, r}) - $signed({1'b0, g});
    end
    if (r <= g) min_c = (r <= b) ? r : b;
    else        min_c = (g <= b) ? g : b;
  end

  function automatic logic hue_lt(input logic signed [19:0] num,
                                  input logic signed [19:0] den,
                                  input logic signed [19:0] deg);
    return num < deg * den;
  endfunction

  logic signed [19:0] d_s, df_s, base_s, h_num;
  logic [17:0]        sat_lhs, sat_rhs;
  logic [2:0]         class_c;

  // h_num / delta is the hue in degrees, already wrapped into [0,360)
  always_comb begin
    d_s  = {12'd0, delta_q};
    df_s = {{11{diff_q[8]}}, diff_q};
    case (sel_q)
      SEL_G:   base_s = 20'sd120 * d_s;
      SEL_B:   base_s = 20'sd240 * d_s;
      default: base_s = diff_q[8] ? 20'sd360 * d_s : '0;
    endcase
    h_num   = base_s + 20'sd60 * df_s;
    sat_lhs = {10'd0, delta_q} * 18'd255;
    sat_rhs = 18'(S_MIN) * {10'd0, max_q};
    class_c = 3'd0;
    if (32'(max_q) < V_MIN || delta_q == '0 || sat_lhs < sat_rhs)
      class_c = 3'd0;
    else if (hue_lt(h_num, d_s, 20'sd20) || !hue_lt(h_num, d_s, 20'sd340))
      class_c = 3'd1;
    else if (!hue_lt(h_num, d_s, 20'sd40) && hue_lt(h_num, d_s, 20'sd70))
      class_c = 3'd2;
    else if (!hue_lt(h_num, d_s, 20'sd90) && hue_lt(h_num, d_s, 20'sd150))
      class_c = 3'd3;
    else if (!hue_lt(h_num, d_s, 20'sd160) && hue_lt(h_num, d_s, 20'sd200))
      class_c = 3'd6;
    else if (!hue_lt(h_num, d_s, 20'sd200) && hue_lt(h_num, d_s, 20'sd260))
      class_c = 3'd4;
    else if (!hue_lt(h_num, d_s, 20'sd300))
      class_c = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q                <= '0;
      max_q                <= '0;
      delta_q              <= '0;
      sel_q                <= SEL_R;
      diff_q               <= '0;
      pixel_classification <= '0;
    end else begin
      pix_q                <= pixel_in;
      max_q                <= max_c;
      delta_q              <= max_c - min_c;
      sel_q                <= sel_c;
      diff_q               <= diff_c;
      pixel_classification <= class_c;
    end
  end

endmodule

// File: tb/tb_pixel_proc.sv
// Self-checking bench for pixel_proc: directed table, test-plan sequences,
// and a randomized stream compared against a floating-point hue model.
module tb_pixel_proc;

  localparam int unsigned V_MIN = 64;
  localparam int unsigned S_MIN = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pixel_in = '0;
  logic [2:0]  pixel_classification;

  int passed = 0;
  int total  = 0;
  logic [2:0] mq [3];

  pixel_proc #(.V_MIN(V_MIN), .S_MIN(S_MIN)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pixel_in             (pixel_in),
    .pixel_classification (pixel_classification)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_class(input logic [23:0] p);
    int r, g, b, mx, mn, d;
    real h;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    if (mx < int'(V_MIN) || d == 0 || d * 255 < int'(S_MIN) * mx) return 3'd0;
    if (r == mx) begin
      h = 60.0 * real'(g - b) / real'(d);
      if (h < 0.0) h = h + 360.0;
    end else if (g == mx) h = 120.0 + 60.0 * real'(b - r) / real'(d);
    else                  h = 240.0 + 60.0 * real'(r - g) / real'(d);
    if (h < 20.0 || h >= 340.0) return 3'd1;
    if (h >= 40.0 && h < 70.0)   return 3'd2;
    if (h >= 90.0 && h < 150.0)  return 3'd3;
    if (h >= 160.0 && h < 200.0) return 3'd6;
    if (h >= 200.0 && h < 260.0) return 3'd4;
    if (h >= 300.0 && h < 340.0) return 3'd5;
    return 3'd0;
  endfunction

  task automatic step(input logic [23:0] p, input logic r);
    pixel_in = p;
    rst      = r;
    @(posedge clk);
    #1;
    if (r) mq = '{3'd0, 3'd0, 3'd0};
    else begin
      mq[2] = mq[1];
      mq[1] = mq[0];
      mq[0] = ref_class(p);
    end
  endtask

  task automatic check(input string name, input logic [2:0] exp);
    total++;
    if (pixel_classification === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, pixel_classification, exp);
  endtask

  typedef struct {
    logic [23:0] pix;
    logic [2:0]  cls;
  } vec_t;

  vec_t vecs[$];
  logic [23:0] stream_pix[6];
  logic [2:0]  stream_cls[6];

  initial begin
    vecs = '{
      '{24'hFF5400, 3'd1}, '{24'hFF5500, 3'd0}, '{24'hFF00FF, 3'd5},
      '{24'hFF0055, 3'd1}, '{24'h3F0000, 3'd0}, '{24'h400000, 3'd1},
      '{24'hFFA0A0, 3'd0}, '{24'hFF9B9B, 3'd1}, '{24'hFFFF00, 3'd2},
      '{24'h00FF00, 3'd3}, '{24'h00FFFF, 3'd6}, '{24'h0000FF, 3'd4},
      '{24'h808080, 3'd0}, '{24'h000000, 3'd0}, '{24'hFF8000, 3'd0},
      '{24'h8000FF, 3'd0}
    };
    stream_pix = '{24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'hFF00FF, 24'h808080, 24'h300000};
    stream_cls = '{3'd2, 3'd3, 3'd6, 3'd5, 3'd0, 3'd0};

    // Reset with red on the input, then release
    step(24'hFF0000, 1'b1); check("reset_0", 3'd0);
    step(24'hFF0000, 1'b1); check("reset_1", 3'd0);
    step(24'hFF0000, 1'b0); check("post_rst_e1", 3'd0);
    step(24'hFF0000, 1'b0); check("post_rst_e2", 3'd0);
    step(24'hFF0000, 1'b0); check("post_rst_e3", 3'd1);
    step(24'hFF0000, 1'b0); check("red_hold_4", 3'd1);
    step(24'hFF0000, 1'b0); check("red_hold_5", 3'd1);

    // Switch red -> blue
    step(24'h0000FF, 1'b0); check("switch_e1", 3'd1);
    step(24'h0000FF, 1'b0); check("switch_e2", 3'd1);
    step(24'h0000FF, 1'b0); check("switch_e3", 3'd4);

    // Back-to-back stream, no bubbles
    for (int i = 0; i < 8; i++) begin
      step((i < 6) ? stream_pix[i] : 24'h300000, 1'b0);
      if (i >= 2) check($sformatf("stream_%0d", i - 2), stream_cls[i - 2]);
    end
    step(24'h300000, 1'b0); check("stream_4", stream_cls[4]);
    step(24'h300000, 1'b0); check("stream_5", stream_cls[5]);

    // Directed table: hold each pixel through the pipeline
    foreach (vecs[i]) begin
      for (int k = 0; k < 3; k++) step(vecs[i].pix, 1'b0);
      check($sformatf("vec_%06h", vecs[i].pix), vecs[i].cls);
    end

    // Mid-stream reset flush
    for (int k = 0; k < 3; k++) step(24'h00FF00, 1'b0);
    check("mid_pre", 3'd3);
    step(24'h00FF00, 1'b1); check("mid_rst", 3'd0);
    step(24'h00FF00, 1'b0); check("mid_e1", 3'd0);
    step(24'h00FF00, 1'b0); check("mid_e2", 3'd0);
    step(24'h00FF00, 1'b0); check("mid_e3", 3'd3);

    // Randomized stream vs reference model, with occasional resets
    for (int i = 0; i < 2000; i++) begin
      logic [23:0] p;
      logic        r;
      p = $urandom;
      if ($urandom_range(0, 3) == 0) p[$urandom_range(0, 2) * 8 +: 8] = 8'hFF;
      if ($urandom_range(0, 3) == 0) p[$urandom_range(0, 2) * 8 +: 8] = 8'h00;
      r = ($urandom_range(0, 63) == 0);
      step(p, r);
      check("random", mq[2]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
